// File: rtl/adj_key_conditioner.sv
// Purpose : synchronise, debounce and pulse-encode the two clock time-adjust keys (AdjH, AdjM).
// Latency : press pulse and Held rise 2+DB_CYCLES edges after the raw key is first sampled high.
// Backpressure: none; the pulses are fire-and-forget single-cycle strobes, so no consumer can stall them.
//
// Ports:
//   CP50      in   system clock, all state on the rising edge
//   nCR       in   asynchronous active-low reset
//   AdjH/AdjM in   raw active-high keys, asynchronous to CP50
//   AdjHPulse/AdjMPulse out  registered one-cycle increment pulses
//   AdjHHeld/AdjMHeld   out  registered, high while the key is accepted and held
//
// Build option: define ADJ_AUTOREPEAT_EN to add the hold-then-repeat path
// (HOLD_CYCLES to the first repeat, then one pulse every RPT_CYCLES).
// Without it a held key yields exactly one pulse per accepted press.

module adj_key_conditioner #(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int RPT_CYCLES  = 5_000_000
) (
    input  logic CP50,
    input  logic nCR,
    input  logic AdjH,
    input  logic AdjM,
    output logic AdjHPulse,
    output logic AdjMPulse,
    output logic AdjHHeld,
    output logic AdjMHeld
);

    localparam int MAX_DH = (DB_CYCLES > HOLD_CYCLES) ? DB_CYCLES : HOLD_CYCLES;
    localparam int MAX_C  = (MAX_DH > RPT_CYCLES) ? MAX_DH : RPT_CYCLES;
    localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
`ifdef ADJ_AUTOREPEAT_EN
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] RPT_LAST  = CW'(RPT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_DB_PRESS   = 3'd1,
        S_HOLD       = 3'd2,
`ifdef ADJ_AUTOREPEAT_EN
        S_REPEAT     = 3'd3,
`endif
        S_DB_RELEASE = 3'd4
    } state_t;

    logic [1:0] key_raw;
    assign key_raw = {AdjM, AdjH};

    // Channel 0 = hour key, channel 1 = minute key; the channels share nothing.
    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic            sync1;
        logic            s;
        state_t          state;
        logic [CW-1:0]   cnt;
        logic            pulse;
        logic            held;

        // Two-flop synchroniser; s is the only version of the key the FSM sees.
        always_ff @(posedge CP50 or negedge nCR) begin
            if (!nCR) begin
                sync1 <= 1'b0;
                s     <= 1'b0;
            end else begin
                sync1 <= key_raw[ch];
                s     <= sync1;
            end
        end

        // One counter serves debounce, hold and repeat timing: it clears on
        // every state change and otherwise free-runs, so each state measures
        // time since it was entered.
        always_ff @(posedge CP50 or negedge nCR) begin
            if (!nCR) begin
                state <= S_IDLE;
                cnt   <= '0;
                pulse <= 1'b0;
                held  <= 1'b0;
            end else begin
                pulse <= 1'b0;
                cnt   <= cnt + CW'(1);
                case (state)
                    S_IDLE: begin
                        if (s) begin
                            state <= S_DB_PRESS;
                            cnt   <= '0;
                        end
                    end
                    S_DB_PRESS: begin
                        if (!s) begin
                            // Too short to be a press: drop it silently.
                            state <= S_IDLE;
                            cnt   <= '0;
                        end else if (cnt == DB_LAST) begin
                            state <= S_HOLD;
                            cnt   <= '0;
                            pulse <= 1'b1;
                            held  <= 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (!s) begin
                            state <= S_DB_RELEASE;
                            cnt   <= '0;
                            held  <= 1'b0;
                        end
`ifdef ADJ_AUTOREPEAT_EN
                        else if (cnt == HOLD_LAST) begin
                            state <= S_REPEAT;
                            cnt   <= '0;
                            pulse <= 1'b1;
                        end
`endif
                    end
`ifdef ADJ_AUTOREPEAT_EN
                    S_REPEAT: begin
                        // Release wins over a coincident repeat tick.
                        if (!s) begin
                            state <= S_DB_RELEASE;
                            cnt   <= '0;
                            held  <= 1'b0;
                        end else if (cnt == RPT_LAST) begin
                            cnt   <= '0;
                            pulse <= 1'b1;
                        end
                    end
`endif
                    S_DB_RELEASE: begin
                        // Any high sample restarts the quiet period, so a
                        // re-press here is absorbed as bounce until the key
                        // has been low for DB_CYCLES consecutive cycles.
                        if (s) begin
                            cnt <= '0;
                        end else if (cnt == DB_LAST) begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        held  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign AdjHPulse = g_ch[0].pulse;
    assign AdjMPulse = g_ch[1].pulse;
    assign AdjHHeld  = g_ch[0].held;
    assign AdjMHeld  = g_ch[1].held;

endmodule

// File: tb/tb_adj_key_conditioner.sv
// Purpose : directed check of adj_key_conditioner with DB=4, HOLD=20, RPT=8.
// Latency : expected pulse/held edges are hand-derived from the raw sample edge k.
// Backpressure: n/a; outputs are observed on the falling clock edge.

module tb_adj_key_conditioner;

    logic CP50 = 1'b0;
    logic nCR;
    logic AdjH, AdjM;
    logic AdjHPulse, AdjMPulse, AdjHHeld, AdjMHeld;

    adj_key_conditioner #(
        .DB_CYCLES  (4),
        .HOLD_CYCLES(20),
        .RPT_CYCLES (8)
    ) dut (
        .CP50     (CP50),
        .nCR      (nCR),
        .AdjH     (AdjH),
        .AdjM     (AdjM),
        .AdjHPulse(AdjHPulse),
        .AdjMPulse(AdjMPulse),
        .AdjHHeld (AdjHHeld),
        .AdjMHeld (AdjMHeld)
    );

    always #5 CP50 = ~CP50;

    int cyc = 0;
    always @(posedge CP50) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Edge numbers (cyc at the following negedge) of pulses and held transitions.
    int hq[$], mq[$], hrise[$], hfall[$], mrise[$], mfall[$];
    logic h_prev = 1'b0, m_prev = 1'b0;

    always @(negedge CP50) begin
        if (AdjHPulse) hq.push_back(cyc);
        if (AdjMPulse) mq.push_back(cyc);
        if (AdjHHeld && !h_prev) hrise.push_back(cyc);
        if (!AdjHHeld && h_prev) hfall.push_back(cyc);
        if (AdjMHeld && !m_prev) mrise.push_back(cyc);
        if (!AdjMHeld && m_prev) mfall.push_back(cyc);
        h_prev = AdjHHeld;
        m_prev = AdjMHeld;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [63:0] ones(input int lo, input int hi);
        logic [63:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic int outs();
        return {28'd0, AdjHPulse, AdjMPulse, AdjHHeld, AdjMHeld};
    endfunction

    // Bit i of hp/mp is the key level sampled at edge k+i; then both keys idle.
    task automatic play(input logic [63:0] hp, input logic [63:0] mp,
                        input int len, output int k);
        hq.delete(); mq.delete(); hrise.delete(); hfall.delete();
        mrise.delete(); mfall.delete();
        @(negedge CP50);
        k = cyc + 1;
        for (int i = 0; i < len; i++) begin
            AdjH = hp[i];
            AdjM = mp[i];
            @(negedge CP50);
        end
        AdjH = 1'b0;
        AdjM = 1'b0;
        repeat (40) @(negedge CP50);
    endtask

    logic [63:0] p;
    int k, k2, len, n_exp, t_rst;
    int exp_p[6] = '{6, 26, 34, 42, 50, 58};

    initial begin
        nCR  = 1'b0;
        AdjH = 1'b0;
        AdjM = 1'b0;
        repeat (3) @(negedge CP50);
        check_eq("reset_outputs", outs(), 0);
        nCR = 1'b1;
        repeat (5) @(negedge CP50);
        check_eq("idle_outputs", outs(), 0);

        // Long single press on AdjH.
`ifdef ADJ_AUTOREPEAT_EN
        len = 60; n_exp = 6;
`else
        len = 40; n_exp = 1;
`endif
        play(ones(0, len - 1), 64'd0, len, k);
        check_eq("t1_h_pulse_count", hq.size(), n_exp);
        for (int i = 0; i < n_exp; i++)
            check_eq($sformatf("t1_h_pulse%0d", i), qget(hq, i), k + exp_p[i]);
        check_eq("t1_h_held_rise", qget(hrise, 0), k + 6);
        check_eq("t1_h_held_fall", qget(hfall, 0), k + len + 2);
        check_eq("t1_m_pulse_count", mq.size(), 0);
        check_eq("t1_m_held_rises", mrise.size(), 0);

        // 3-cycle glitch on AdjM is rejected.
        play(64'd0, ones(0, 2), 3, k);
        check_eq("t2_glitch_pulses", mq.size(), 0);
        check_eq("t2_glitch_held", mrise.size(), 0);

        // Glitch then immediate real press: FSM must have gone back to IDLE.
        play(64'd0, ones(0, 2) | ones(4, 13), 14, k);
        check_eq("t2_repress_count", mq.size(), 1);
        check_eq("t2_repress_edge", qget(mq, 0), k + 10);

        // Clean press then bouncy release (low 1, high 2, for 15 cycles).
        p = ones(0, 9);
        for (int i = 10; i < 25; i++) if ((i - 10) % 3 != 0) p[i] = 1'b1;
        play(p, 64'd0, 30, k);
        check_eq("t3_pulse_count", hq.size(), 1);
        check_eq("t3_pulse_edge", qget(hq, 0), k + 6);
        check_eq("t3_held_fall", qget(hfall, 0), k + 12);
        check_eq("t3_held_rises", hrise.size(), 1);

        // Re-press one edge before release debounce completes: absorbed.
        play(p | ones(28, 37), 64'd0, 40, k);
        check_eq("t3_early_repress", hq.size(), 1);

        // Re-press one edge later: FSM reached IDLE at k+30, new press accepted.
        play(p | ones(29, 38), 64'd0, 40, k);
        check_eq("t3_late_count", hq.size(), 2);
        check_eq("t3_late_edge", qget(hq, 1), k + 35);

        // Both keys together pulse in the same cycle.
        play(ones(0, 9), ones(0, 9), 10, k);
        check_eq("t5_h_count", hq.size(), 1);
        check_eq("t5_m_count", mq.size(), 1);
        check_eq("t5_h_edge", qget(hq, 0), k + 6);
        check_eq("t5_m_edge", qget(mq, 0), k + 6);

        // Reset while held (REPEAT when auto-repeat is built, HOLD otherwise).
`ifdef ADJ_AUTOREPEAT_EN
        t_rst = 30;
`else
        t_rst = 15;
`endif
        @(negedge CP50);
        AdjH = 1'b1;
        k = cyc + 1;
        repeat (t_rst + 1) @(negedge CP50);
        check_eq("t6_held_before", {31'd0, AdjHHeld}, 1);
        nCR = 1'b0;
        #1;
        check_eq("t6_async_clear", outs(), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CP50);
            check_eq($sformatf("t6_in_reset%0d", i), outs(), 0);
        end
        hq.delete(); hrise.delete(); hfall.delete();
        nCR = 1'b1;
        k2 = cyc + 1;
        repeat (16) @(negedge CP50);
        AdjH = 1'b0;
        repeat (40) @(negedge CP50);
        check_eq("t6_pulse_count", hq.size(), 1);
        check_eq("t6_pulse_edge", qget(hq, 0), k2 + 6);
        check_eq("t6_held_rise", qget(hrise, 0), k2 + 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
